clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 22 ++
 rtl/wrap_inc.sv | 19 +
 rtl/clock_set_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting controller.
// Optional feature macro: ALARM_EN (adds the alarm-setting states).
package clock_pkg;

    localparam int unsigned HH_W   = 5;
    localparam int unsigned MM_W   = 6;
    localparam int unsigned HH_MAX = 23;
    localparam int unsigned MM_MAX = 59;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_HH = 3'd1,
        ST_SET_MM = 3'd2,
        ST_COMMIT = 3'd3
`ifdef ALARM_EN
        ,
        ST_SET_AH = 3'd4,
        ST_SET_AM = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/wrap_inc.sv
// Increment-with-wrap for one edited time field: MAX rolls over to 0.
module wrap_inc #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic [W-1:0] val_i,
    input  logic         inc_i,
    output logic [W-1:0] val_o
);

    // Next field value; unchanged unless an increment is requested
    always_comb begin
        val_o = val_i;
        if (inc_i) begin
            val_o = (val_i == W'(MAX)) ? '0 : val_i + W'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a HH:MM:SS clock: walks the user through
// editing hours and minutes, then loads them into the datapath.
// Optional feature macro: ALARM_EN (alarm time editing and alarm_o output).
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode_btn,
    input  logic            inc_btn,
    input  logic [HH_W-1:0] cur_hh,
    input  logic [MM_W-1:0] cur_mm,
    input  logic [MM_W-1:0] cur_ss,
    output logic            run_en,
    output logic            load,
    output logic [HH_W-1:0] load_hh,
    output logic [MM_W-1:0] load_mm,
    output logic            blink,
    output logic [2:0]      state_o
`ifdef ALARM_EN
    ,
    output logic            alarm_o
`endif
);

    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t          state_q, state_d;
    logic            run_en_q, run_en_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            blink_q, blink_d;
    logic [HH_W-1:0] edit_hh_q, edit_hh_d, hh_nxt;
    logic [MM_W-1:0] edit_mm_q, edit_mm_d, mm_nxt;
    logic            capture;
    logic            in_set;

    // mode_btn wins over inc_btn, so increments only fire on mode-free cycles
    assign capture = (state_q == ST_RUN) && mode_btn;

    wrap_inc #(.W(HH_W), .MAX(HH_MAX)) u_inc_hh (
        .val_i (edit_hh_q),
        .inc_i ((state_q == ST_SET_HH) && inc_btn && !mode_btn),
        .val_o (hh_nxt)
    );

    wrap_inc #(.W(MM_W), .MAX(MM_MAX)) u_inc_mm (
        .val_i (edit_mm_q),
        .inc_i ((state_q == ST_SET_MM) && inc_btn && !mode_btn),
        .val_o (mm_nxt)
    );

`ifdef ALARM_EN
    logic            armed_q, armed_d;
    logic [HH_W-1:0] alarm_hh_q, alarm_hh_d;
    logic [MM_W-1:0] alarm_mm_q, alarm_mm_d;

    wrap_inc #(.W(HH_W), .MAX(HH_MAX)) u_inc_ah (
        .val_i (alarm_hh_q),
        .inc_i ((state_q == ST_SET_AH) && inc_btn && !mode_btn),
        .val_o (alarm_hh_d)
    );

    wrap_inc #(.W(MM_W), .MAX(MM_MAX)) u_inc_am (
        .val_i (alarm_mm_q),
        .inc_i ((state_q == ST_SET_AM) && inc_btn && !mode_btn),
        .val_o (alarm_mm_d)
    );
`else
    logic unused_ss;
    assign unused_ss = ^cur_ss;
`endif

    // Next-state, edit-field and blink-timer logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blink_d   = blink_q;
        edit_hh_d = capture ? cur_hh : hh_nxt;
        edit_mm_d = capture ? cur_mm : mm_nxt;
`ifdef ALARM_EN
        armed_d   = armed_q;
`endif

        case (state_q)
            ST_RUN:    if (mode_btn) state_d = ST_SET_HH;
            ST_SET_HH: if (mode_btn) state_d = ST_SET_MM;
`ifdef ALARM_EN
            ST_SET_MM: if (mode_btn) state_d = ST_SET_AH;
            ST_SET_AH: if (mode_btn) state_d = ST_SET_AM;
            ST_SET_AM: if (mode_btn) state_d = ST_COMMIT;
            ST_COMMIT: begin
                state_d = ST_RUN;
                armed_d = 1'b1;
            end
`else
            ST_SET_MM: if (mode_btn) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_RUN;
`endif
            default:   state_d = ST_RUN;
        endcase

        // Blink phase restarts on every state change so each field starts lit
        in_set = (state_q != ST_RUN) && (state_q != ST_COMMIT);
        if (state_d != state_q) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (in_set) begin
            if (cnt_q == CW'(BLINK_DIV - 1)) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        run_en_d = (state_d == ST_RUN);
    end

    // State and field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            run_en_q   <= 1'b1;
            cnt_q      <= '0;
            blink_q    <= 1'b0;
            edit_hh_q  <= '0;
            edit_mm_q  <= '0;
`ifdef ALARM_EN
            armed_q    <= 1'b0;
            alarm_hh_q <= '0;
            alarm_mm_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            run_en_q   <= run_en_d;
            cnt_q      <= cnt_d;
            blink_q    <= blink_d;
            edit_hh_q  <= edit_hh_d;
            edit_mm_q  <= edit_mm_d;
`ifdef ALARM_EN
            armed_q    <= armed_d;
            alarm_hh_q <= alarm_hh_d;
            alarm_mm_q <= alarm_mm_d;
`endif
        end
    end

    assign run_en  = run_en_q;
    assign load    = (state_q == ST_COMMIT);
    assign load_hh = edit_hh_q;
    assign load_mm = edit_mm_q;
    assign blink   = blink_q;
    assign state_o = state_q;

`ifdef ALARM_EN
    assign alarm_o = (state_q == ST_RUN) && armed_q && (cur_hh == alarm_hh_q)
                     && (cur_mm == alarm_mm_q) && (cur_ss == '0);
`endif

endmodule
